// File: rtl/pc_pkg.sv
// Shared definitions for the fetch-stage next-PC unit and its return-address stack.
// Holds default widths, next-PC source encodings and instruction field positions.
// Optional build macro used by the top level: PC_RET_STACK_HALT_EN.
package pc_pkg;

  // Default widths
  localparam int ADDR_W_DEF = 12;
  localparam int OFS_W_DEF  = 8;
  localparam int INSTR_W    = 19;

  // Instruction field positions: jump target [11:0], branch offset [7:0]
  localparam int JMP_LSB = 0;
  localparam int JMP_MSB = 11;
  localparam int OFS_LSB = 0;
  localparam int OFS_MSB = 7;

  // Next-PC source select; 2'b11 is reserved and behaves as sequential
  typedef enum logic [1:0] {
    SEL_SEQ = 2'b00,
    SEL_BR  = 2'b01,
    SEL_JMP = 2'b10,
    SEL_RSV = 2'b11
  } sel_e;

  // Fetch address at the default width
  typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/ret_addr_stack.sv
// DEPTH x ADDR_W LIFO holding return addresses; synchronous write, combinational top.
// Latency: push/pop take effect on the next rising edge; top reflects the current sp.
// Backpressure: none; push when full and pop when empty are ignored (caller flags them).
module ret_addr_stack #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_en,
  input  logic                       pop_en,
  input  logic [ADDR_W-1:0]          wdata,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(DEPTH):0]     sp,
  output logic                       full,
  output logic                       empty
);

  localparam int SP_W  = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(DEPTH);

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;

  assign sp_m1 = sp_q - SP_W'(1);
  assign full  = (sp_q == SP_W'(DEPTH));
  assign empty = (sp_q == '0);
  assign sp    = sp_q;
  // When empty the read index wraps to the last slot; callers never use it then.
  assign top   = mem_q[sp_m1[IDX_W-1:0]];

  // Occupancy next state: pop has priority, both saturate at the bounds
  always_comb begin
    sp_d = sp_q;
    if (pop_en && !empty) begin
      sp_d = sp_m1;
    end else if (push_en && !full) begin
      sp_d = sp_q + SP_W'(1);
    end
  end

  // Occupancy register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp_q <= '0;
    end else begin
      sp_q <= sp_d;
    end
  end

  // Entry storage; contents are not reset, only sp defines what is valid
  always_ff @(posedge clk) begin
    if (push_en && !full && !pop_en) begin
      mem_q[sp_q[IDX_W-1:0]] <= wdata;
    end
  end

endmodule

// File: rtl/pc_ret_stack.sv
// Fetch-stage next-PC unit: PC register, next-PC mux, return-address stack, sticky flags.
// Latency: PC is registered, next address appears one cycle after the controls.
// Backpressure: enablePC=0 holds everything; with PC_RET_STACK_HALT_EN an error freezes it.
module pc_ret_stack
  import pc_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH  = 8,
  parameter int OFS_W  = OFS_W_DEF
) (
  input  logic                   clock,
  input  logic                   init_signal,
  input  logic                   enablePC,
  input  logic [INSTR_W-1:0]     allBits,
  input  logic [1:0]             selectAdress,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   RET,
  output logic [ADDR_W-1:0]      PC,
  output logic [$clog2(DEPTH):0] sp,
  output logic                   stackOverflow,
  output logic                   stackUnderflow,
  output logic                   halted
);

  logic [ADDR_W-1:0] pc_q, pc_d, pc_nxt, pc_inc, br_tgt, jmp_tgt, stk_top;
  logic              ovf_q, ovf_d, unf_q, unf_d;
  logic              ovf_evt, unf_evt, active, commit;
  logic              stk_push, stk_pop, stk_full, stk_empty;
  logic              unused_bits;

  // Instruction bits above the jump target are not consumed here
  assign unused_bits = ^allBits[INSTR_W-1:ADDR_W];

  assign pc_inc  = pc_q + ADDR_W'(1);
  assign jmp_tgt = allBits[JMP_LSB +: ADDR_W];
  assign br_tgt  = pc_inc + {{(ADDR_W-OFS_W){allBits[OFS_LSB+OFS_W-1]}},
                             allBits[OFS_LSB +: OFS_W]};

`ifdef PC_RET_STACK_HALT_EN
  logic halt_q, halt_d;
  assign active = enablePC && !halt_q;
  assign halted = halt_q;
`else
  assign active = enablePC;
  assign halted = 1'b0;
`endif

  // Next-PC selection: return/pop beats call, call beats selectAdress
  always_comb begin
    pc_nxt   = pc_inc;
    stk_push = 1'b0;
    stk_pop  = 1'b0;
    ovf_evt  = 1'b0;
    unf_evt  = 1'b0;
    if (RET || pop) begin
      if (stk_empty) begin
        unf_evt = 1'b1;
      end else begin
        stk_pop = 1'b1;
        if (RET) begin
          pc_nxt = stk_top;
        end
      end
    end else if (push) begin
      // The jump of a call is taken even when the return address cannot be saved
      if (stk_full) begin
        ovf_evt = 1'b1;
      end else begin
        stk_push = 1'b1;
      end
      pc_nxt = jmp_tgt;
    end else begin
      case (sel_e'(selectAdress))
        SEL_BR:  pc_nxt = br_tgt;
        SEL_JMP: pc_nxt = jmp_tgt;
        default: pc_nxt = pc_inc;
      endcase
    end
  end

  // Commit gating and sticky flag next state
  always_comb begin
    ovf_d  = ovf_q;
    unf_d  = unf_q;
    commit = 1'b0;
`ifdef PC_RET_STACK_HALT_EN
    halt_d = halt_q;
`endif
    if (active) begin
      ovf_d = ovf_q || ovf_evt;
      unf_d = unf_q || unf_evt;
`ifdef PC_RET_STACK_HALT_EN
      // An error freezes the machine on the very cycle it is detected
      halt_d = halt_q || ovf_evt || unf_evt;
      commit = !(ovf_evt || unf_evt);
`else
      commit = 1'b1;
`endif
    end
    pc_d = commit ? pc_nxt : pc_q;
  end

  // PC and flag registers
  always_ff @(posedge clock or negedge init_signal) begin
    if (!init_signal) begin
      pc_q  <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

`ifdef PC_RET_STACK_HALT_EN
  // Halt latch, cleared only by reset
  always_ff @(posedge clock or negedge init_signal) begin
    if (!init_signal) begin
      halt_q <= 1'b0;
    end else begin
      halt_q <= halt_d;
    end
  end
`endif

  ret_addr_stack #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_stack (
    .clk     (clock),
    .rst_n   (init_signal),
    .push_en (stk_push && commit),
    .pop_en  (stk_pop && commit),
    .wdata   (pc_inc),
    .top     (stk_top),
    .sp      (sp),
    .full    (stk_full),
    .empty   (stk_empty)
  );

  assign PC             = pc_q;
  assign stackOverflow  = ovf_q;
  assign stackUnderflow = unf_q;

endmodule
